// File: rtl/mac_ctrl_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : mac_ctrl_multi_if
// Description : Accumulator-side and result-side bus of the multi-channel MAC
//               result controller.
// Revision    : 1.0  initial release
// ============================================================================
interface mac_ctrl_multi_if #(
    parameter int DATA_W = 16,
    parameter int N_CH   = 4
) ();
    logic                   start;
    logic [N_CH-1:0]        ac_rdy;
    logic [N_CH*DATA_W-1:0] ac_out;
    logic [N_CH-1:0]        ac_ovf;
    logic [N_CH*DATA_W-1:0] mac_out;
    logic                   mac_vld;
    logic                   mac_ack;
    logic                   busy;
    logic [N_CH-1:0]        sat_flag;

    modport master (
        output start, ac_rdy, ac_out, ac_ovf, mac_ack,
        input  mac_out, mac_vld, busy, sat_flag
    );

    modport slave (
        input  start, ac_rdy, ac_out, ac_ovf, mac_ack,
        output mac_out, mac_vld, busy, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/mac_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module      : mac_ctrl_multi
// Description : Counts per-channel accumulator strobes, latches (saturating)
//               channel sums and hands the full result set downstream.
// Revision    : 1.0  initial release
// ============================================================================
module mac_ctrl_multi #(
    parameter int DATA_W  = 16,
    parameter int N_CH    = 4,
    parameter int N_TERMS = 16
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mac_ctrl_multi_if.slave    bus
);
    localparam int CNT_W = $clog2(N_TERMS + 1);

    localparam logic [CNT_W-1:0]  c_TERMS   = CNT_W'(N_TERMS);
    localparam logic [CNT_W-1:0]  c_ONE     = CNT_W'(1);
    localparam logic [DATA_W-1:0] c_SAT_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] c_SAT_POS = {1'b0, {(DATA_W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt [N_CH];
    logic [N_CH*DATA_W-1:0] r_mac_out;
    logic [N_CH-1:0]        r_sat;
    logic                   r_vld;
    logic                   r_busy;

    logic [N_CH-1:0]        w_full;
    logic                   w_all_full;
    logic                   w_clear;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_full
        assign w_full[gi] = (r_cnt[gi] == c_TERMS);
    end

    assign w_all_full = &w_full;

    // A pending result may only be replaced once it has been acknowledged.
    assign w_clear = bus.start &&
                     ((r_state == S_IDLE) || (r_state == S_ACCUM) ||
                      ((r_state == S_DONE) && bus.mac_ack));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mac_out <= '0;
            r_sat     <= '0;
            r_vld     <= 1'b0;
            r_busy    <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_clear) begin
            r_state   <= S_ACCUM;
            r_mac_out <= '0;
            r_sat     <= '0;
            r_vld     <= 1'b0;
            r_busy    <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_vld  <= 1'b0;
                    r_busy <= 1'b0;
                end
                S_ACCUM: begin
                    if (w_all_full) begin
                        r_state <= S_DONE;
                        r_vld   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        for (int i = 0; i < N_CH; i++) begin
                            if (bus.ac_rdy[i] && !w_full[i]) begin
                                r_cnt[i] <= r_cnt[i] + c_ONE;
                                // Overflow re-saturates using the sign of the offending word.
                                if (bus.ac_ovf[i]) begin
                                    r_mac_out[i*DATA_W +: DATA_W] <=
                                        bus.ac_out[i*DATA_W + DATA_W - 1] ? c_SAT_NEG : c_SAT_POS;
                                    r_sat[i] <= 1'b1;
                                end else if (!r_sat[i]) begin
                                    r_mac_out[i*DATA_W +: DATA_W] <= bus.ac_out[i*DATA_W +: DATA_W];
                                end
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.mac_ack) begin
                        r_state <= S_IDLE;
                        r_vld   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mac_out  = r_mac_out;
    assign bus.mac_vld  = r_vld;
    assign bus.busy     = r_busy;
    assign bus.sat_flag = r_sat;

endmodule
`default_nettype wire
